sprite_anim_rom: RTL and testbench



---
 rtl/sprite_pkg.sv | 42 ++++
 rtl/sprite_anim_rom_if.sv | 34 +++
 rtl/sprite_bank_rom.sv | 34 +++
 rtl/sprite_anim_rom.sv | 139 +++++++++++++
 tb/tb_sprite_anim_rom.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sprite_pkg.sv
// Shared types and helpers for the sprite animation ROM.
// dir_t        : facing direction as supplied by gameplay logic
// anim_state_t : animation sequencer state
// rom_addr()   : linear bank address of one pixel
// Optional feature macro: SPRITE_ANIM_HFLIP_EN (LEFT drawn as mirrored RIGHT).
package sprite_pkg;

    typedef enum logic [1:0] {
        DIR_DOWN  = 2'd0,
        DIR_UP    = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WALK   = 2'd1,
        ATTACK = 2'd2
    } anim_state_t;

    localparam int unsigned DIR_W = 2;

`ifdef SPRITE_ANIM_HFLIP_EN
    localparam int unsigned DIRS_STORED = 3;
`else
    localparam int unsigned DIRS_STORED = 4;
`endif

    // Slot-major layout; with power-of-two sprite dimensions the low bits are {y, x}.
    function automatic int unsigned rom_addr(
        input int unsigned slot,
        input int unsigned seq_frame,
        input int unsigned y,
        input int unsigned x,
        input int unsigned seq_frames,
        input int unsigned h,
        input int unsigned w
    );
        return ((slot * seq_frames + seq_frame) * h + y) * w + x;
    endfunction

endpackage

// File: rtl/sprite_anim_rom_if.sv
// Bus between gameplay/colour-mapper logic and sprite_anim_rom.
// master: drives frame_tick, dir_in, walking, attack_start, pix_x, pix_y;
//         receives q, transparent, busy, cur_dir, cur_frame.
// slave : the sprite block itself.
interface sprite_anim_rom_if
    import sprite_pkg::*;
#(
    parameter int unsigned X_W   = 5,
    parameter int unsigned Y_W   = 5,
    parameter int unsigned PIX_W = 3,
    parameter int unsigned FRM_W = 2
);
    logic             frame_tick;
    dir_t             dir_in;
    logic             walking;
    logic             attack_start;
    logic [X_W-1:0]   pix_x;
    logic [Y_W-1:0]   pix_y;
    logic [PIX_W-1:0] q;
    logic             transparent;
    logic             busy;
    dir_t             cur_dir;
    logic [FRM_W-1:0] cur_frame;

    modport master (
        output frame_tick, dir_in, walking, attack_start, pix_x, pix_y,
        input  q, transparent, busy, cur_dir, cur_frame
    );

    modport slave (
        input  frame_tick, dir_in, walking, attack_start, pix_x, pix_y,
        output q, transparent, busy, cur_dir, cur_frame
    );
endinterface

// File: rtl/sprite_bank_rom.sv
// Single-port synchronous ROM holding every sprite frame of one character.
// Ports: clock, reset_n (sync, active-low), addr, match_val,
//        rdata (registered word), match (registered rdata == match_val).
// An empty INIT_FILE gives a blank bank that reads all zeros.
module sprite_bank_rom #(
    parameter int unsigned DEPTH     = 24576,
    parameter int unsigned PIX_W     = 3,
    parameter string       INIT_FILE = "sprite.mif"
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [PIX_W-1:0]         match_val,
    output logic [PIX_W-1:0]         rdata,
    output logic                     match
);
    localparam bit HAS_INIT = (INIT_FILE != "");

    (* ram_init_file = INIT_FILE *) logic [PIX_W-1:0] mem [DEPTH];

    // Compare is done on the raw word so the flag shares the data register stage.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rdata <= '0;
            match <= 1'b1;
        end else if (HAS_INIT) begin
            rdata <= mem[addr];
            match <= (mem[addr] == match_val);
        end else begin
            rdata <= '0;
            match <= (match_val == '0);
        end
    end
endmodule

// File: rtl/sprite_anim_rom.sv
// Sprite store plus animation sequencer for one character.
// Ports: clock, reset_n (sync, active-low), bus (sprite_anim_rom_if.slave):
//   frame_tick/dir_in/walking/attack_start drive the sequencer,
//   pix_x/pix_y address a pixel, q/transparent return it one cycle later,
//   busy/cur_dir/cur_frame expose the sequencer state.
// Optional feature macro: SPRITE_ANIM_HFLIP_EN (LEFT = mirrored RIGHT, 3 slots stored).
module sprite_anim_rom
    import sprite_pkg::*;
#(
    parameter int unsigned SPRITE_W        = 32,
    parameter int unsigned SPRITE_H        = 32,
    parameter int unsigned PIX_W           = 3,
    parameter int unsigned WALK_FRAMES     = 2,
    parameter int unsigned ATK_FRAMES      = 4,
    parameter int unsigned TICKS_PER_FRAME = 8,
    parameter int unsigned TRANSP_IDX      = 0,
    parameter string       INIT_FILE       = "sprite.mif"
) (
    input logic              clock,
    input logic              reset_n,
    sprite_anim_rom_if.slave bus
);
    localparam int unsigned MAX_FRAMES = (WALK_FRAMES > ATK_FRAMES) ? WALK_FRAMES : ATK_FRAMES;
    localparam int unsigned FRM_W      = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;
    localparam int unsigned TICK_W     = $clog2(TICKS_PER_FRAME) + 1;
    localparam int unsigned SEQ_FRAMES = WALK_FRAMES + ATK_FRAMES;
    localparam int unsigned DEPTH      = DIRS_STORED * SEQ_FRAMES * SPRITE_W * SPRITE_H;
    localparam int unsigned ADDR_W     = $clog2(DEPTH);

    anim_state_t       state, state_n;
    dir_t              cur_dir, dir_n;
    logic [FRM_W-1:0]  cur_frame, frame_n;
    logic [TICK_W-1:0] tick_cnt, tick_n;
    logic              pending, pending_n;
    logic              busy, busy_n;
    logic              step_done;
    logic              atk_req;
    int unsigned       slot, rd_x, seq_frame;
    logic [ADDR_W-1:0] addr;

    assign step_done = (tick_cnt == TICK_W'(TICKS_PER_FRAME - 1));
    assign atk_req   = pending | bus.attack_start;

    // State register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= IDLE;
            cur_dir   <= DIR_DOWN;
            cur_frame <= '0;
            tick_cnt  <= '0;
            pending   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            cur_dir   <= dir_n;
            cur_frame <= frame_n;
            tick_cnt  <= tick_n;
            pending   <= pending_n;
            busy      <= busy_n;
        end
    end

    // Next state: only frame_tick moves the sequencer; attack beats walking.
    always_comb begin
        state_n = state;
        if (bus.frame_tick) begin
            unique case (state)
                IDLE: begin
                    if (atk_req)          state_n = ATTACK;
                    else if (bus.walking) state_n = WALK;
                end
                WALK: begin
                    if (atk_req)           state_n = ATTACK;
                    else if (!bus.walking) state_n = IDLE;
                end
                ATTACK: begin
                    if (step_done && (cur_frame == FRM_W'(ATK_FRAMES - 1)))
                        state_n = bus.walking ? WALK : IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Sequencer outputs: direction, frame, tick counter, pending flag, busy
    always_comb begin
        dir_n     = cur_dir;
        frame_n   = cur_frame;
        tick_n    = tick_cnt;
        busy_n    = busy;
        pending_n = pending | (bus.attack_start & (state != ATTACK));
        if (bus.frame_tick) begin
            if (state != ATTACK) dir_n = bus.dir_in;
            if ((state_n != state) || (state == IDLE)) begin
                frame_n = '0;
                tick_n  = '0;
            end else if (step_done) begin
                tick_n  = '0;
                frame_n = (state == WALK)
                        ? FRM_W'((32'(cur_frame) + 32'd1) % WALK_FRAMES)
                        : cur_frame + FRM_W'(1);
            end else begin
                tick_n = tick_cnt + TICK_W'(1);
            end
            busy_n = (state_n == ATTACK);
            if (state_n == ATTACK) pending_n = 1'b0;
        end
    end

    // ROM address from the registered sequencer state and live pixel coordinate
    always_comb begin
        slot = 32'(cur_dir);
        rd_x = 32'(bus.pix_x);
`ifdef SPRITE_ANIM_HFLIP_EN
        if ((cur_dir == DIR_LEFT) || (cur_dir == DIR_RIGHT)) slot = 32'd2;
        if (cur_dir == DIR_LEFT) rd_x = SPRITE_W - 32'd1 - 32'(bus.pix_x);
`endif
        seq_frame = (state == ATTACK) ? (WALK_FRAMES + 32'(cur_frame)) : 32'(cur_frame);
        addr = ADDR_W'(rom_addr(slot, seq_frame, 32'(bus.pix_y), rd_x,
                                SEQ_FRAMES, SPRITE_H, SPRITE_W));
    end

    sprite_bank_rom #(
        .DEPTH     (DEPTH),
        .PIX_W     (PIX_W),
        .INIT_FILE (INIT_FILE)
    ) u_rom (
        .clock     (clock),
        .reset_n   (reset_n),
        .addr      (addr),
        .match_val (PIX_W'(TRANSP_IDX)),
        .rdata     (bus.q),
        .match     (bus.transparent)
    );

    assign bus.busy      = busy;
    assign bus.cur_dir   = cur_dir;
    assign bus.cur_frame = cur_frame;
endmodule

// File: tb/tb_sprite_anim_rom.sv
// Self-checking bench for sprite_anim_rom (default parameters).
module tb_sprite_anim_rom;
    import sprite_pkg::*;

`ifdef SPRITE_ANIM_HFLIP_EN
    localparam int unsigned TB_DEPTH = 3 * 6 * 32 * 32;
`else
    localparam int unsigned TB_DEPTH = 4 * 6 * 32 * 32;
`endif

    logic clock;
    logic reset_n;
    int   checks;
    int   failures;

    sprite_anim_rom_if #(.X_W(5), .Y_W(5), .PIX_W(3), .FRM_W(2)) bus ();

    sprite_anim_rom dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Preload pattern: a mix that yields zeros (transparent) and non-zeros.
    function automatic logic [2:0] pat(input int unsigned a);
        return 3'((a * 7) + (a >> 5) + (a >> 10) * 3);
    endfunction

    // Expected pixel address straight from the bank layout description.
    function automatic int unsigned exp_addr(input dir_t d, input bit atk, input int unsigned f,
                                             input int unsigned x, input int unsigned y);
        int unsigned slot;
        int unsigned xx;
        slot = int'(d);
        xx   = x;
`ifdef SPRITE_ANIM_HFLIP_EN
        if (d == DIR_LEFT) begin
            slot = 2;
            xx   = 31 - x;
        end else if (d == DIR_RIGHT) begin
            slot = 2;
        end
`endif
        return slot * 6 * 1024 + (atk ? 2 + f : f) * 1024 + y * 32 + xx;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_tick();
        bus.frame_tick = 1'b1;
        step();
        bus.frame_tick = 1'b0;
    endtask

    task automatic gap(input int unsigned n);
        repeat (n) step();
    endtask

    task automatic apply_reset();
        reset_n          = 1'b0;
        bus.frame_tick   = 1'b0;
        bus.walking      = 1'b0;
        bus.attack_start = 1'b0;
        bus.dir_in       = DIR_DOWN;
        gap(3);
        reset_n = 1'b1;
        step();
    endtask

    function automatic dir_t rnd_dir();
        return dir_t'(2'($urandom_range(0, 3)));
    endfunction

    task automatic test_reset();
        reset_n    = 1'b0;
        bus.pix_x  = 5'($urandom_range(0, 31));
        bus.pix_y  = 5'($urandom_range(0, 31));
        bus.dir_in = DIR_RIGHT;
        gap(3);
        checks += 5;
        if (bus.q !== 3'd0) begin failures++; $display("FAIL reset_q got=%0d exp=0", bus.q); end
        if (bus.transparent !== 1'b1) begin failures++; $display("FAIL reset_transparent got=%0b exp=1", bus.transparent); end
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
        if (bus.cur_dir !== DIR_DOWN) begin failures++; $display("FAIL reset_dir got=%0d exp=0", bus.cur_dir); end
        if (bus.cur_frame !== 2'd0) begin failures++; $display("FAIL reset_frame got=%0d exp=0", bus.cur_frame); end
        reset_n     = 1'b1;
        bus.walking = 1'b0;
        bus.dir_in  = DIR_UP;
        gap(2);
        do_tick();
        checks += 3;
        if (bus.cur_frame !== 2'd0) begin failures++; $display("FAIL idle_tick_frame got=%0d exp=0", bus.cur_frame); end
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL idle_tick_busy got=%0b exp=0", bus.busy); end
        if (bus.cur_dir !== DIR_UP) begin failures++; $display("FAIL idle_tick_dir got=%0d exp=1", bus.cur_dir); end
    endtask

    task automatic test_walk();
        int unsigned ef;
        apply_reset();
        bus.walking = 1'b1;
        bus.dir_in  = DIR_RIGHT;
        for (int k = 1; k <= 20; k++) begin
            gap($urandom_range(0, 2));
            do_tick();
            ef = ((k - 1) / 8) % 2;
            checks += 3;
            if (bus.cur_frame !== 2'(ef)) begin failures++; $display("FAIL walk_frame tick=%0d got=%0d exp=%0d", k, bus.cur_frame, ef); end
            if (bus.cur_dir !== DIR_RIGHT) begin failures++; $display("FAIL walk_dir tick=%0d got=%0d exp=3", k, bus.cur_dir); end
            if (bus.busy !== 1'b0) begin failures++; $display("FAIL walk_busy tick=%0d got=%0b exp=0", k, bus.busy); end
        end
        bus.walking = 1'b0;
        do_tick();
        checks++;
        if (bus.cur_frame !== 2'd0) begin failures++; $display("FAIL walk_stop_frame got=%0d exp=0", bus.cur_frame); end
    endtask

    task automatic test_attack();
        int unsigned ef;
        bit          eb;
        dir_t        d;
        apply_reset();
        bus.walking      = 1'b0;
        bus.dir_in       = DIR_UP;
        bus.attack_start = 1'b1;
        do_tick();
        bus.attack_start = 1'b0;
        checks += 3;
        if (bus.busy !== 1'b1) begin failures++; $display("FAIL attack_enter_busy got=%0b exp=1", bus.busy); end
        if (bus.cur_frame !== 2'd0) begin failures++; $display("FAIL attack_enter_frame got=%0d exp=0", bus.cur_frame); end
        if (bus.cur_dir !== DIR_UP) begin failures++; $display("FAIL attack_enter_dir got=%0d exp=1", bus.cur_dir); end
        for (int k = 1; k <= 32; k++) begin
            if (k == 5) begin
                bus.attack_start = 1'b1;
                step();
            end
            gap($urandom_range(0, 2));
            bus.dir_in = rnd_dir();
            do_tick();
            bus.attack_start = 1'b0;
            eb = (k < 32);
            ef = (k < 32) ? k / 8 : 0;
            checks += 3;
            if (bus.busy !== eb) begin failures++; $display("FAIL attack_busy tick=%0d got=%0b exp=%0b", k, bus.busy, eb); end
            if (bus.cur_frame !== 2'(ef)) begin failures++; $display("FAIL attack_frame tick=%0d got=%0d exp=%0d", k, bus.cur_frame, ef); end
            if (bus.cur_dir !== DIR_UP) begin failures++; $display("FAIL attack_dir_frozen tick=%0d got=%0d exp=1", k, bus.cur_dir); end
        end
        d = rnd_dir();
        bus.dir_in = d;
        do_tick();
        checks += 2;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL attack_not_queued got=%0b exp=0", bus.busy); end
        if (bus.cur_dir !== d) begin failures++; $display("FAIL attack_after_dir got=%0d exp=%0d", bus.cur_dir, d); end
    endtask

    task automatic test_pending();
        apply_reset();
        bus.walking      = 1'b1;
        bus.attack_start = 1'b1;
        step();
        bus.attack_start = 1'b0;
        gap($urandom_range(1, 4));
        checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL pending_early_busy got=%0b exp=0", bus.busy); end
        do_tick();
        checks += 2;
        if (bus.busy !== 1'b1) begin failures++; $display("FAIL pending_enter_busy got=%0b exp=1", bus.busy); end
        if (bus.cur_frame !== 2'd0) begin failures++; $display("FAIL pending_enter_frame got=%0d exp=0", bus.cur_frame); end
        repeat (32) do_tick();
        checks += 2;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL pending_done_busy got=%0b exp=0", bus.busy); end
        if (bus.cur_frame !== 2'd0) begin failures++; $display("FAIL pending_done_frame got=%0d exp=0", bus.cur_frame); end
    endtask

    task automatic test_reset_mid_attack();
        apply_reset();
        bus.dir_in       = DIR_LEFT;
        bus.attack_start = 1'b1;
        do_tick();
        bus.attack_start = 1'b0;
        repeat (9) do_tick();
        checks += 2;
        if (bus.busy !== 1'b1) begin failures++; $display("FAIL midatk_busy got=%0b exp=1", bus.busy); end
        if (bus.cur_frame !== 2'd1) begin failures++; $display("FAIL midatk_frame got=%0d exp=1", bus.cur_frame); end
        reset_n        = 1'b0;
        bus.frame_tick = 1'b1;
        step();
        bus.frame_tick = 1'b0;
        checks += 3;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL midatk_reset_busy got=%0b exp=0", bus.busy); end
        if (bus.cur_frame !== 2'd0) begin failures++; $display("FAIL midatk_reset_frame got=%0d exp=0", bus.cur_frame); end
        if (bus.cur_dir !== DIR_DOWN) begin failures++; $display("FAIL midatk_reset_dir got=%0d exp=0", bus.cur_dir); end
        reset_n = 1'b1;
        step();
        // A captured request must not survive a reset.
        bus.attack_start = 1'b1;
        step();
        bus.attack_start = 1'b0;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        do_tick();
        checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_clears_pending got=%0b exp=0", bus.busy); end
    endtask

    task automatic test_rom_sweep();
        dir_t        ed;
        bit          ea;
        int unsigned ef;
        int unsigned x;
        int unsigned y;
        logic [2:0]  ew;
        apply_reset();
        ed = DIR_DOWN;
        ea = 1'b0;
        ef = 0;
        for (int c = 0; c < 7; c++) begin
            case (c)
                0: begin bus.walking = 1'b0; ed = rnd_dir(); bus.dir_in = ed; do_tick(); end
                1: begin bus.walking = 1'b1; ed = rnd_dir(); bus.dir_in = ed; do_tick(); end
                2: begin
                    repeat (8) begin ed = rnd_dir(); bus.dir_in = ed; do_tick(); end
                    ef = 1;
                end
                3: begin
                    ed = rnd_dir();
                    bus.dir_in = ed;
                    bus.attack_start = 1'b1;
                    do_tick();
                    bus.attack_start = 1'b0;
                    ea = 1'b1;
                    ef = 0;
                end
                default: begin
                    repeat (8) begin bus.dir_in = rnd_dir(); do_tick(); end
                    ef = c - 3;
                end
            endcase
            for (int i = 0; i < 10; i++) begin
                x = $urandom_range(0, 31);
                y = $urandom_range(0, 31);
                bus.pix_x = 5'(x);
                bus.pix_y = 5'(y);
                step();
                ew = pat(exp_addr(ed, ea, ef, x, y));
                checks += 2;
                if (bus.q !== ew) begin failures++; $display("FAIL rom_q ctx=%0d x=%0d y=%0d got=%0d exp=%0d", c, x, y, bus.q, ew); end
                if (bus.transparent !== (ew == 3'd0)) begin failures++; $display("FAIL rom_transparent ctx=%0d got=%0b exp=%0b", c, bus.transparent, (ew == 3'd0)); end
            end
        end
    endtask

`ifdef SPRITE_ANIM_HFLIP_EN
    task automatic test_hflip();
        int unsigned y;
        logic [2:0]  ew;
        apply_reset();
        bus.dir_in = DIR_LEFT;
        do_tick();
        for (int i = 0; i < 4; i++) begin
            y = $urandom_range(0, 31);
            bus.pix_x = 5'd0;
            bus.pix_y = 5'(y);
            step();
            ew = pat(2 * 6 * 1024 + y * 32 + 31);
            checks++;
            if (bus.q !== ew) begin failures++; $display("FAIL hflip_left y=%0d got=%0d exp=%0d", y, bus.q, ew); end
        end
    endtask
`endif

    initial begin
        checks           = 0;
        failures         = 0;
        reset_n          = 1'b0;
        bus.frame_tick   = 1'b0;
        bus.walking      = 1'b0;
        bus.attack_start = 1'b0;
        bus.dir_in       = DIR_DOWN;
        bus.pix_x        = '0;
        bus.pix_y        = '0;
        for (int a = 0; a < int'(TB_DEPTH); a++) dut.u_rom.mem[a] = pat(a);
        test_reset();
        test_walk();
        test_attack();
        test_pending();
        test_reset_mid_attack();
        test_rom_sweep();
`ifdef SPRITE_ANIM_HFLIP_EN
        test_hflip();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
